// File: rtl/time_counter_pkg.sv
// Shared types and BCD helpers for the time-of-day counter.
// Used by bcd_mod_counter and time_counter_bcd.
package time_counter_pkg;

    typedef logic [7:0] bcd2_t;

    localparam bcd2_t BCD_ZERO = 8'h00;

    localparam int unsigned DEF_SEC_MOD  = 60;
    localparam int unsigned DEF_MIN_MOD  = 60;
    localparam int unsigned DEF_HOUR_MOD = 24;

    function automatic logic bcd_valid(input bcd2_t v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic bcd_lt(input bcd2_t v, input int unsigned m);
        int unsigned b;
        b = 32'(v[7:4]) * 10 + 32'(v[3:0]);
        return b < m;
    endfunction

    function automatic bcd2_t bin2bcd(input int unsigned b);
        return {4'(b / 10), 4'(b % 10)};
    endfunction

    // One modulo-m BCD increment: wraps to zero from the terminal value m-1.
    function automatic bcd2_t bcd_step(input bcd2_t v, input int unsigned m);
        bcd2_t r;
        if (v == bin2bcd(m - 1))
            r = BCD_ZERO;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo-MOD counter with synchronous load and terminal-count flag.
module bcd_mod_counter
    import time_counter_pkg::*;
#(
    parameter int unsigned MOD = 60
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  inc,
    input  logic  load,
    input  bcd2_t ld_val,
    output bcd2_t val,
    output logic  tc
);

    localparam bcd2_t TC_VAL = bin2bcd(MOD - 1);

    bcd2_t val_q, val_d;

    always_comb begin
        val_d = val_q;
        if (load)
            val_d = ld_val;
        else if (inc)
            val_d = bcd_step(val_q, MOD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            val_q <= BCD_ZERO;
        else
            val_q <= val_d;
    end

    assign val = val_q;
    assign tc  = (val_q == TC_VAL);

endmodule

// File: rtl/time_counter_bcd.sv
// Three-stage BCD time-of-day counter (ss/mm/hh) with load, run/hold and day carry.
// Optional alarm comparator enabled by defining TIME_COUNTER_ALARM_EN.
module time_counter_bcd
    import time_counter_pkg::*;
#(
    parameter int unsigned SEC_MOD  = DEF_SEC_MOD,
    parameter int unsigned MIN_MOD  = DEF_MIN_MOD,
    parameter int unsigned HOUR_MOD = DEF_HOUR_MOD
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  tick,
    input  logic  run,
    input  logic  load,
    input  bcd2_t ld_sec,
    input  bcd2_t ld_min,
    input  bcd2_t ld_hour,
`ifdef TIME_COUNTER_ALARM_EN
    input  logic  alarm_set,
    input  bcd2_t alarm_hour,
    input  bcd2_t alarm_min,
    output logic  alarm_hit,
`endif
    output bcd2_t sec_bcd,
    output bcd2_t min_bcd,
    output bcd2_t hour_bcd,
    output logic  day_pulse,
    output logic  load_err
);

    logic ld_ok, load_go, adv;
    logic sec_tc, min_tc, hour_tc;
    logic day_pulse_q, day_pulse_d;
    logic load_err_q, load_err_d;

    assign ld_ok = bcd_valid(ld_sec)  && bcd_lt(ld_sec, SEC_MOD)
                && bcd_valid(ld_min)  && bcd_lt(ld_min, MIN_MOD)
                && bcd_valid(ld_hour) && bcd_lt(ld_hour, HOUR_MOD);

    // Any load request, valid or not, swallows a coincident tick.
    assign load_go = load && ld_ok;
    assign adv     = tick && run && !load;

    bcd_mod_counter #(.MOD(SEC_MOD)) u_sec (
        .clk(clk), .rst(rst), .inc(adv), .load(load_go),
        .ld_val(ld_sec), .val(sec_bcd), .tc(sec_tc)
    );

    bcd_mod_counter #(.MOD(MIN_MOD)) u_min (
        .clk(clk), .rst(rst), .inc(adv && sec_tc), .load(load_go),
        .ld_val(ld_min), .val(min_bcd), .tc(min_tc)
    );

    bcd_mod_counter #(.MOD(HOUR_MOD)) u_hour (
        .clk(clk), .rst(rst), .inc(adv && sec_tc && min_tc), .load(load_go),
        .ld_val(ld_hour), .val(hour_bcd), .tc(hour_tc)
    );

    assign day_pulse_d = adv && sec_tc && min_tc && hour_tc;

`ifdef TIME_COUNTER_ALARM_EN
    bcd2_t al_hour_q, al_hour_d, al_min_q, al_min_d;
    bcd2_t min_next, hour_next;
    logic  al_ok, alarm_hit_q, alarm_hit_d;

    assign al_ok = bcd_valid(alarm_hour) && bcd_lt(alarm_hour, HOUR_MOD)
                && bcd_valid(alarm_min)  && bcd_lt(alarm_min, MIN_MOD);

    // Time the minute/hour stages take on this tick when seconds wrap to 00.
    assign min_next  = bcd_step(min_bcd, MIN_MOD);
    assign hour_next = min_tc ? bcd_step(hour_bcd, HOUR_MOD) : hour_bcd;

    always_comb begin
        al_hour_d   = al_hour_q;
        al_min_d    = al_min_q;
        alarm_hit_d = adv && sec_tc && (min_next == al_min_q) && (hour_next == al_hour_q);
        load_err_d  = (load && !ld_ok) || (alarm_set && !al_ok);
        if (alarm_set && al_ok) begin
            al_hour_d = alarm_hour;
            al_min_d  = alarm_min;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            al_hour_q   <= BCD_ZERO;
            al_min_q    <= BCD_ZERO;
            alarm_hit_q <= 1'b0;
        end else begin
            al_hour_q   <= al_hour_d;
            al_min_q    <= al_min_d;
            alarm_hit_q <= alarm_hit_d;
        end
    end

    assign alarm_hit = alarm_hit_q;
`else
    assign load_err_d = load && !ld_ok;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            day_pulse_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            day_pulse_q <= day_pulse_d;
            load_err_q  <= load_err_d;
        end
    end

    assign day_pulse = day_pulse_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_time_counter_bcd.sv
// Directed bench for time_counter_bcd: default-modulus instance plus a 12-hour instance.
module tb_time_counter_bcd;

    logic clk = 1'b0;
    logic rst, tick, run, load;
    logic [7:0] ld_sec, ld_min, ld_hour;
    logic [7:0] s1, m1, h1, s2, m2, h2;
    logic dp1, le1, dp2, le2;
`ifdef TIME_COUNTER_ALARM_EN
    logic alarm_set, ah1, ah2;
    logic [7:0] alarm_hour, alarm_min;
`endif

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    time_counter_bcd dut1 (
        .clk(clk), .rst(rst), .tick(tick), .run(run), .load(load),
        .ld_sec(ld_sec), .ld_min(ld_min), .ld_hour(ld_hour),
`ifdef TIME_COUNTER_ALARM_EN
        .alarm_set(alarm_set), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
        .alarm_hit(ah1),
`endif
        .sec_bcd(s1), .min_bcd(m1), .hour_bcd(h1),
        .day_pulse(dp1), .load_err(le1)
    );

    time_counter_bcd #(.HOUR_MOD(12)) dut2 (
        .clk(clk), .rst(rst), .tick(tick), .run(run), .load(load),
        .ld_sec(ld_sec), .ld_min(ld_min), .ld_hour(ld_hour),
`ifdef TIME_COUNTER_ALARM_EN
        .alarm_set(alarm_set), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
        .alarm_hit(ah2),
`endif
        .sec_bcd(s2), .min_bcd(m2), .hour_bcd(h2),
        .day_pulse(dp2), .load_err(le2)
    );

    typedef struct {
        logic        ld;
        logic        tk;
        logic        rn;
        logic [23:0] ld_t;
        logic [23:0] exp_t;
        logic        exp_day;
        logic        exp_err;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            pass_cnt++;
    endtask

    // Drive current inputs through one rising edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
        load = 1'b0;
        tick = 1'b0;
`ifdef TIME_COUNTER_ALARM_EN
        alarm_set = 1'b0;
`endif
    endtask

    initial begin
        int day_cnt;
        int hit_cnt;
        int hit_idx;

        rst = 1'b0; tick = 1'b0; run = 1'b0; load = 1'b0;
        ld_sec = 8'h00; ld_min = 8'h00; ld_hour = 8'h00;
`ifdef TIME_COUNTER_ALARM_EN
        alarm_set = 1'b0; alarm_hour = 8'h00; alarm_min = 8'h00;
`endif

        vecs[0]  = '{1, 0, 1, 24'h235958, 24'h235958, 0, 0};
        vecs[1]  = '{0, 1, 1, 24'h000000, 24'h235959, 0, 0};
        vecs[2]  = '{0, 1, 1, 24'h000000, 24'h000000, 1, 0};
        vecs[3]  = '{0, 0, 1, 24'h000000, 24'h000000, 0, 0};
        vecs[4]  = '{1, 0, 1, 24'h127A00, 24'h000000, 0, 1};
        vecs[5]  = '{1, 0, 1, 24'h126000, 24'h000000, 0, 1};
        vecs[6]  = '{1, 1, 1, 24'h240000, 24'h000000, 0, 1};
        vecs[7]  = '{0, 1, 0, 24'h000000, 24'h000000, 0, 0};
        vecs[8]  = '{1, 0, 0, 24'h053000, 24'h053000, 0, 0};
        vecs[9]  = '{0, 1, 0, 24'h000000, 24'h053000, 0, 0};
        vecs[10] = '{1, 1, 1, 24'h010203, 24'h010203, 0, 0};
        vecs[11] = '{0, 1, 1, 24'h000000, 24'h010204, 0, 0};
        vecs[12] = '{1, 0, 1, 24'h005959, 24'h005959, 0, 0};
        vecs[13] = '{0, 1, 1, 24'h000000, 24'h010000, 0, 0};
        vecs[14] = '{1, 0, 1, 24'h093909, 24'h093909, 0, 0};
        vecs[15] = '{0, 1, 1, 24'h000000, 24'h093910, 0, 0};
        vecs[16] = '{1, 0, 1, 24'h09395A, 24'h093910, 0, 1};
        vecs[17] = '{1, 0, 1, 24'h230059, 24'h230059, 0, 0};
        vecs[18] = '{0, 1, 1, 24'h000000, 24'h230100, 0, 0};
        vecs[19] = '{1, 0, 0, 24'h235959, 24'h235959, 0, 0};
        vecs[20] = '{0, 1, 0, 24'h000000, 24'h235959, 0, 0};
        vecs[21] = '{0, 1, 1, 24'h000000, 24'h000000, 1, 0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_time", {8'h0, h1, m1, s1}, 32'h0);
        chk("reset_flags", {30'h0, dp1, le1}, 32'h0);
`ifdef TIME_COUNTER_ALARM_EN
        chk("reset_alarm_hit", {31'h0, ah1}, 32'h0);
`endif
        rst = 1'b1;
        run = 1'b1;

        // 61 back-to-back ticks from reset
        day_cnt = 0;
        for (int i = 0; i < 61; i++) begin
            tick = 1'b1;
            step();
            if (dp1) day_cnt++;
            if (i == 0)
                chk("first_tick", {8'h0, h1, m1, s1}, 32'h000001);
        end
        $display("61 ticks: time %h:%h:%h day_pulses %0d", h1, m1, s1, day_cnt);
        chk("ticks61_time", {8'h0, h1, m1, s1}, 32'h000101);
        chk("ticks61_no_day", day_cnt, 0);

        for (int i = 0; i < 22; i++) begin
            load    = vecs[i].ld;
            tick    = vecs[i].tk;
            run     = vecs[i].rn;
            ld_hour = vecs[i].ld_t[23:16];
            ld_min  = vecs[i].ld_t[15:8];
            ld_sec  = vecs[i].ld_t[7:0];
            step();
            $display("vec %0d: ld=%0b tk=%0b run=%0b -> %h:%h:%h day=%0b err=%0b",
                     i, vecs[i].ld, vecs[i].tk, vecs[i].rn, h1, m1, s1, dp1, le1);
            chk($sformatf("vec%0d_time", i), {8'h0, h1, m1, s1}, {8'h0, vecs[i].exp_t});
            chk($sformatf("vec%0d_flags", i), {30'h0, dp1, le1},
                {30'h0, vecs[i].exp_day, vecs[i].exp_err});
        end

        // Asynchronous reset mid-operation, then resume counting
        run = 1'b1;
        tick = 1'b1;
        step();
        chk("pre_reset_tick", {8'h0, h1, m1, s1}, 32'h000001);
        rst = 1'b0;
        #2;
        chk("async_reset_time", {8'h0, h1, m1, s1}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick = 1'b1;
        step();
        $display("after reset release + tick: %h:%h:%h", h1, m1, s1);
        chk("resume_after_reset", {8'h0, h1, m1, s1}, 32'h000001);

        // 12-hour instance: rollover from 11:59:59
        load = 1'b1;
        ld_hour = 8'h11; ld_min = 8'h59; ld_sec = 8'h59;
        step();
        chk("h12_load", {8'h0, h2, m2, s2}, 32'h115959);
        tick = 1'b1;
        step();
        $display("h12 tick: %h:%h:%h day=%0b", h2, m2, s2, dp2);
        chk("h12_rollover_time", {8'h0, h2, m2, s2}, 32'h000000);
        chk("h12_day_pulse", {31'h0, dp2}, 32'h1);
        chk("h24_no_rollover", {8'h0, h1, m1, s1}, 32'h120000);
`ifdef TIME_COUNTER_ALARM_EN
        chk("h12_alarm_at_reset_value", {31'h0, ah2}, 32'h1);
`endif
        step();
        chk("h12_day_pulse_one_cycle", {31'h0, dp2}, 32'h0);

`ifdef TIME_COUNTER_ALARM_EN
        alarm_set = 1'b1; alarm_hour = 8'h00; alarm_min = 8'h60;
        step();
        $display("alarm set 00:60: load_err=%0b", le2);
        chk("alarm_invalid_err", {31'h0, le2}, 32'h1);
        alarm_set = 1'b1; alarm_hour = 8'h00; alarm_min = 8'h01;
        step();
        chk("alarm_valid_no_err", {31'h0, le2}, 32'h0);
        hit_cnt = 0;
        hit_idx = -1;
        for (int i = 0; i < 60; i++) begin
            tick = 1'b1;
            step();
            if (ah2) begin
                hit_cnt++;
                hit_idx = i;
            end
        end
        $display("alarm run: %h:%h:%h hits=%0d at tick %0d", h2, m2, s2, hit_cnt, hit_idx);
        chk("alarm_time", {8'h0, h2, m2, s2}, 32'h000100);
        chk("alarm_hit_count", hit_cnt, 1);
        chk("alarm_hit_tick", hit_idx, 59);
        step();
        chk("alarm_hit_one_cycle", {31'h0, ah2}, 32'h0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
